matrix_stream_tx: RTL and testbench

//  Source-side serializer for the bidiagonalization engine's sample-stream input.
//  - Host loads complex channel matrices into a ping-pong register bank.
//  - Each committed matrix goes out as one contiguous burst: CHANNEL_SIZE cycles, row-major, valid_o high.
//  - Every burst is followed by an enforced idle gap.
//  - Lets the host load frame n+1 while frame n streams.

---
 rtl/bidiag_pkg.sv | 23 ++
 rtl/matrix_bank.sv | 24 ++
 rtl/matrix_stream_tx.sv | 167 ++++++++++++++++
 tb/tb_matrix_stream_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bidiag_pkg.sv
// Shared constants and types for the bidiagonalization sample-stream front end.
// Sample layout is {re, im}, each BIT_NUM-bit signed, stored and streamed bit-exact.
package bidiag_pkg;

  localparam int DIM          = 4;
  localparam int CHANNEL_SIZE = DIM * DIM;
  localparam int BIT_NUM      = 18;
  localparam int ADDR_W       = $clog2(CHANNEL_SIZE);
  localparam int GAP_MIN      = 2;
  localparam int GCNT_W       = (GAP_MIN > 1) ? $clog2(GAP_MIN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } stream_state_t;

  typedef struct packed {
    logic signed [BIT_NUM-1:0] re;
    logic signed [BIT_NUM-1:0] im;
  } sample_t;

endpackage

// File: rtl/matrix_bank.sv
// One CHANNEL_SIZE-entry complex-sample register file: synchronous write, combinational read.
// Contents are deliberately not reset; only the pending flags in the parent gate their use.
module matrix_bank
  import bidiag_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  sample_t           i_wdat,
  input  logic [ADDR_W-1:0] i_raddr,
  output sample_t           o_rdat
);

  sample_t r_mem [CHANNEL_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/matrix_stream_tx.sv
// Ping-pong matrix loader streaming each committed frame as a CHANNEL_SIZE-cycle burst plus GAP_MIN idle cycles.
// Commit to first valid_o is 2 cycles; no output backpressure, host is throttled by full_o (refusals set sticky err_o).
module matrix_stream_tx
  import bidiag_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic signed [BIT_NUM-1:0] wr_re_i,
  input  logic signed [BIT_NUM-1:0] wr_im_i,
  input  logic                      commit_i,
  output logic                      full_o,
  output logic                      valid_o,
  output logic signed [BIT_NUM-1:0] R_o,
  output logic signed [BIT_NUM-1:0] I_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      err_o
);

  logic [1:0]                r_pend;
  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic                      r_err;
  stream_state_t             r_state;
  logic [ADDR_W-1:0]         r_cnt;
  logic [GCNT_W-1:0]         r_gcnt;
  logic                      r_valid;
  logic signed [BIT_NUM-1:0] r_re;
  logic signed [BIT_NUM-1:0] r_im;
  logic                      r_busy;
  logic                      r_frame_done;

  logic                      w_full;
  logic                      w_wr_ok;
  logic                      w_commit_ok;
  logic                      w_last;
  sample_t                   w_wdat;
  sample_t                   w_rdat [2];
  sample_t                   w_rd_sample;
  logic [1:0]                w_we;

  assign w_full      = r_pend[r_wr_bank];
  assign w_wr_ok     = wr_en_i && !w_full;
  assign w_commit_ok = commit_i && !w_full;
  assign w_last      = (r_state == ST_SEND) && (r_cnt == ADDR_W'(CHANNEL_SIZE - 1));
  assign w_wdat      = {wr_re_i, wr_im_i};
  assign w_rd_sample = r_rd_bank ? w_rdat[1] : w_rdat[0];

  // A write in the commit cycle still targets the bank being committed.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_we[b] = w_wr_ok && (r_wr_bank == 1'(b));

    matrix_bank u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (wr_addr_i),
      .i_wdat  (w_wdat),
      .i_raddr (r_cnt),
      .o_rdat  (w_rdat[b])
    );
  end

  // Set and clear never hit the same bank: a set needs the fill bank idle, a clear needs it streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_wr_bank <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_commit_ok) begin
        r_pend[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_last) begin
        r_pend[r_rd_bank] <= 1'b0;
      end
      if ((wr_en_i || commit_i) && w_full) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rd_bank    <= 1'b0;
      r_cnt        <= '0;
      r_gcnt       <= '0;
      r_valid      <= 1'b0;
      r_re         <= '0;
      r_im         <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid      <= 1'b0;
          r_re         <= '0;
          r_im         <= '0;
          r_frame_done <= 1'b0;
          if (r_pend[r_rd_bank]) begin
            r_state <= ST_SEND;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        ST_SEND: begin
          r_valid      <= 1'b1;
          r_re         <= w_rd_sample.re;
          r_im         <= w_rd_sample.im;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b1;
          r_cnt        <= r_cnt + 1'b1;
          if (w_last) begin
            r_state   <= ST_GAP;
            r_gcnt    <= '0;
            r_rd_bank <= ~r_rd_bank;
          end
        end

        ST_GAP: begin
          r_valid      <= 1'b0;
          r_re         <= '0;
          r_im         <= '0;
          r_frame_done <= (r_gcnt == '0);
          // Chaining straight into SEND keeps back-to-back frames exactly GAP_MIN cycles apart.
          if (r_gcnt == GCNT_W'(GAP_MIN - 1)) begin
            if (r_pend[r_rd_bank]) begin
              r_state <= ST_SEND;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_valid      <= 1'b0;
          r_re         <= '0;
          r_im         <= '0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign full_o       = w_full;
  assign valid_o      = r_valid;
  assign R_o          = r_re;
  assign I_o          = r_im;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: stimulus pushes expected samples, a negedge monitor pops and compares.
// Monitor also checks burst length, gap length, frame_done placement and zeroed data while idle.
module tb_matrix_stream_tx;
  import bidiag_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      wr_en_i;
  logic [ADDR_W-1:0]         wr_addr_i;
  logic signed [BIT_NUM-1:0] wr_re_i;
  logic signed [BIT_NUM-1:0] wr_im_i;
  logic                      commit_i;
  logic                      full_o;
  logic                      valid_o;
  logic signed [BIT_NUM-1:0] R_o;
  logic signed [BIT_NUM-1:0] I_o;
  logic                      busy_o;
  logic                      frame_done_o;
  logic                      err_o;

  typedef struct {
    int re;
    int im;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  int   low_run = 0;
  int   last_gap = 0;
  bit   prev_v = 1'b0;
  bit   seen_burst = 1'b0;

  matrix_stream_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_re_i      (wr_re_i),
    .wr_im_i      (wr_im_i),
    .commit_i     (commit_i),
    .full_o       (full_o),
    .valid_o      (valid_o),
    .R_o          (R_o),
    .I_o          (I_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input int a, input int re, input int im, input logic cm);
    @(negedge clk);
    wr_en_i   = we;
    wr_addr_i = ADDR_W'(a);
    wr_re_i   = BIT_NUM'(re);
    wr_im_i   = BIT_NUM'(im);
    commit_i  = cm;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic push(input int re, input int im);
    exp_t e;
    e.re = re;
    e.im = im;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: every sample presented is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_v     = 1'b0;
      run        = 0;
      low_run    = 0;
      seen_burst = 1'b0;
    end else begin
      if (valid_o) begin
        if (!prev_v) begin
          last_gap = low_run;
          if (seen_burst) chk("gap_min", (low_run >= GAP_MIN) ? 1 : 0, 1);
        end
        chk("fd_in_burst", frame_done_o, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", valid_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("R_o", R_o, e.re);
          chk("I_o", I_o, e.im);
        end
        run++;
        low_run = 0;
      end else begin
        chk("idle_data_zero", (R_o != 0 || I_o != 0) ? 1 : 0, 0);
        if (prev_v) begin
          chk("burst_len", run, CHANNEL_SIZE);
          chk("frame_done_pulse", frame_done_o, 1);
          seen_burst = 1'b1;
        end else begin
          chk("fd_quiet", frame_done_o, 0);
        end
        run = 0;
        low_run++;
      end
      prev_v = valid_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit hit;
    int n;
    rst_n     = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_re_i   = '0;
    wr_im_i   = '0;
    commit_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    // Test 1: reset asserted while idle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_R", R_o, 0);
    chk("rst_I", I_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_fd", frame_done_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Test 2: single frame, R=k, I=-k, latency of two edges
    for (int k = 0; k < CHANNEL_SIZE; k++) drive(1'b1, k, k, -k, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) push(k, -k);
    idle();
    chk("lat_edge_t", valid_o, 0);
    chk("full_after_commit", full_o, 0);
    @(negedge clk);
    chk("lat_edge_t1", valid_o, 0);
    @(negedge clk);
    chk("lat_edge_t2", valid_o, 1);
    wait_drain("drain_single", 40);
    repeat (4) @(negedge clk);

    // Test 3: frame B loaded and committed while A streams
    for (int k = 0; k < CHANNEL_SIZE; k++) drive(1'b1, k, 100 + k, k, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) push(100 + k, k);
    for (int k = 0; k < CHANNEL_SIZE; k++) drive(1'b1, k, 200 + k, -k, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) push(200 + k, -k);
    idle();
    wait_drain("drain_b2b", 80);
    chk("b2b_gap", last_gap, GAP_MIN);
    repeat (4) @(negedge clk);

    // Test 4: overflow; B reuses test-3 B bank with only addrs 0..3 rewritten
    for (int k = 0; k < CHANNEL_SIZE; k++) drive(1'b1, k, 300 + k, -(300 + k), 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) push(300 + k, -(300 + k));
    for (int k = 0; k < 4; k++) drive(1'b1, k, 400 + k, 1000 + k, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) begin
      if (k < 4) push(400 + k, 1000 + k);
      else       push(200 + k, -k);
    end
    drive(1'b1, 0, 'h1FFFF, 'h1FFFF, 1'b0);
    chk("ovf_full", full_o, 1);
    drive(1'b0, 0, 0, 0, 1'b1);
    idle();
    chk("ovf_err", err_o, 1);
    wait_drain("drain_ovf", 80);
    chk("ovf_b2b_gap", last_gap, GAP_MIN);
    repeat (8) @(negedge clk);
    chk("ovf_err_sticky", err_o, 1);
    chk("ovf_busy_idle", busy_o, 0);

    // Test 5: reset during element 7 aborts the burst
    for (int k = 0; k < CHANNEL_SIZE; k++) drive(1'b1, k, 600 + k, -(600 + k), 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE; k++) push(600 + k, -(600 + k));
    idle();
    hit = 1'b0;
    n = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      if (valid_o && R_o == 607) hit = 1'b1;
    end
    chk("abort_reached_elem7", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", valid_o, 0);
    chk("abort_R", R_o, 0);
    chk("abort_err_clr", err_o, 0);
    chk("abort_full", full_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_restart", valid_o, 0);
    chk("abort_busy", busy_o, 0);

    // Test 6: fresh frame, addr 15 written together with commit at min signed value
    for (int k = 0; k < CHANNEL_SIZE - 1; k++) drive(1'b1, k, -(k * 1000), k * 7, 1'b0);
    drive(1'b1, 15, -131072, 131071, 1'b1);
    for (int k = 0; k < CHANNEL_SIZE - 1; k++) push(-(k * 1000), k * 7);
    push(-131072, 131071);
    idle();
    wait_drain("drain_fresh", 40);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
